// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_unit
// Brief    : Instruction-fetch stage. Owns the fetch PC, issues pipelined
//            word requests to instruction memory, tags each request with its
//            PC and buffers in-order responses in a small prefetch FIFO for
//            decode. Redirects flush the FIFO and discard stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en_i,
  input  logic            br_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_rdy_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            id_ready_i
);

  // Pointer width into the tag queue and the prefetch FIFO (DEPTH is 2^n).
  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_C   = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_ALIGN  = {{(XLEN - 2){1'b1}}, 2'b00};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]   tag_wptr_q, tag_wptr_d;
  logic [AW-1:0]   tag_rptr_q, tag_rptr_d;
  logic [AW-1:0]   fifo_wptr_q, fifo_wptr_d;
  logic [AW-1:0]   fifo_rptr_q, fifo_rptr_d;

  logic [XLEN-1:0] tag_mem_q   [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] fifo_inst_q [DEPTH];

  logic [CW:0] credit_used;
  logic        accept;
  logic        rsp;
  logic        drop_rsp;
  logic        push;
  logic        pop;

  // Buffered plus in-flight fetches; new requests only while below DEPTH so
  // every response is guaranteed a FIFO slot.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};

  assign mem_req_o  = rst_n & (state_q == ST_RUN) & fetch_en_i & ~br_i &
                      (credit_used < DEPTH_C);
  assign mem_addr_o = fetch_pc_q;
  assign accept     = mem_req_o & mem_rdy_i;

  // A response with nothing outstanding is ignored so counters never wrap.
  assign rsp      = mem_rvalid_i & (outstanding_q != '0);
  assign drop_rsp = rsp & (drop_cnt_q != '0);
  assign push     = rsp & (drop_cnt_q == '0) & ~br_i;
  assign pop      = inst_valid_o & id_ready_i & ~br_i;

  // Head of the FIFO comes straight from storage flops, never from memory.
  assign inst_valid_o = (fifo_cnt_q != '0);
  assign inst_o       = fifo_inst_q[fifo_rptr_q];
  assign pc_o         = fifo_pc_q[fifo_rptr_q];

  // Next-state computation for PC, counters, pointers and drain state.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q;
    tag_wptr_d    = tag_wptr_q;
    tag_rptr_d    = tag_rptr_q;
    fifo_wptr_d   = fifo_wptr_q;
    fifo_rptr_d   = fifo_rptr_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      tag_wptr_d = tag_wptr_q + AW'(1);
    end
    if (br_i) begin
      fetch_pc_d = br_target_i & PC_ALIGN;
    end

    // Tags leave in response order whether the data is kept or dropped.
    if (rsp) begin
      tag_rptr_d = tag_rptr_q + AW'(1);
    end

    if (accept && !rsp) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!accept && rsp) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    // On redirect, everything still in flight after this cycle is stale.
    if (br_i) begin
      drop_cnt_d = rsp ? (outstanding_q - CW'(1)) : outstanding_q;
    end else if (drop_rsp) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (br_i) begin
      fifo_cnt_d  = '0;
      fifo_wptr_d = '0;
      fifo_rptr_d = '0;
    end else begin
      if (push) begin
        fifo_wptr_d = fifo_wptr_q + AW'(1);
      end
      if (pop) begin
        fifo_rptr_d = fifo_rptr_q + AW'(1);
      end
      if (push && !pop) begin
        fifo_cnt_d = fifo_cnt_q + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt_d = fifo_cnt_q - CW'(1);
      end
    end

    if (br_i) begin
      state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end else if ((state_q == ST_DRAIN) && (drop_cnt_d == '0)) begin
      state_d = ST_RUN;
    end
  end

  // State, counter, pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      fifo_wptr_q   <= '0;
      fifo_rptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_q[i]   <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      tag_wptr_q    <= tag_wptr_d;
      tag_rptr_q    <= tag_rptr_d;
      fifo_wptr_q   <= fifo_wptr_d;
      fifo_rptr_q   <= fifo_rptr_d;
      if (accept) begin
        tag_mem_q[tag_wptr_q] <= fetch_pc_q;
      end
      if (push) begin
        fifo_pc_q[fifo_wptr_q]   <= tag_mem_q[tag_rptr_q];
        fifo_inst_q[fifo_wptr_q] <= mem_rdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_unit
// Brief    : Randomised bench for if_prefetch_unit with an in-order memory
//            model, a program-order reference model and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        br_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        id_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i), .br_i(br_i),
    .br_target_i(br_target_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdy_i(mem_rdy_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .id_ready_i(id_ready_i)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  sbq[$];    // expected deliveries, program order
  mreq_t memq[$];   // accepted requests awaiting a memory response

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  int cyc = 0;
  logic [31:0] model_pc = RESET_PC;
  int drops = 0;
  int acc_cnt = 0;
  int deliver_cnt = 0;
  int first_acc_cyc = -1;
  int first_val_cyc = -1;
  int wrap_seen = 0;

  // stimulus knobs (percentages / latency range)
  int  k_en = 0, k_rdy = 0, k_id = 0, k_br = 0, k_rsp = 100;
  int  k_lat_min = 1, k_lat_max = 1;
  bit  force_br = 1'b0;
  logic [31:0] force_tgt = '0;

  function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Stimulus + memory model + reference model of fetch order
  initial begin : stim
    logic exp_req;
    int   lat;
    forever begin
      @(negedge clk);
      cyc++;
      if (!run) begin
        fetch_en_i = 1'b0; br_i = 1'b0; mem_rdy_i = 1'b0;
        mem_rvalid_i = 1'b0; id_ready_i = 1'b0;
        continue;
      end
      fetch_en_i = pct(k_en);
      mem_rdy_i  = pct(k_rdy);
      id_ready_i = pct(k_id);
      if (force_br) begin
        br_i = 1'b1; br_target_i = force_tgt; force_br = 1'b0;
      end else begin
        br_i = pct(k_br);
        br_target_i = pct(15) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      end
      if (memq.size() > 0 && cyc >= memq[0].due && pct(k_rsp)) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = memq[0].addr ^ KEY;
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
      #1;
      assert (!mem_rvalid_i || memq.size() > 0);
      // Requests are allowed only in program-order run mode with credit left.
      exp_req = fetch_en_i && !br_i && (drops == 0) && (sbq.size() < DEPTH);
      chk(mem_req_o == exp_req, "mem_req", 32'(mem_req_o), 32'(exp_req));
      chk(mem_addr_o == model_pc, "mem_addr", mem_addr_o, model_pc);
      if (mem_rvalid_i) begin
        void'(memq.pop_front());
        if (drops > 0) drops--;
      end
      if (mem_req_o && mem_rdy_i) begin
        lat = k_lat_min + int'($urandom_range(k_lat_max - k_lat_min));
        sbq.push_back('{pc: model_pc, inst: model_pc ^ KEY});
        memq.push_back('{addr: mem_addr_o, due: cyc + lat});
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        acc_cnt++;
        model_pc = model_pc + 32'd4;
      end
      if (br_i) begin
        sbq.delete();
        drops    = memq.size();
        model_pc = br_target_i & 32'hFFFF_FFFC;
      end
    end
  end

  // Monitor: pops the scoreboard whenever decode consumes the head
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (run && inst_valid_o && !br_i) begin
        if (first_val_cyc < 0) first_val_cyc = cyc;
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_valid", pc_o, 32'hxxxx_xxxx);
        end else if (id_ready_i) begin
          e = sbq.pop_front();
          chk(pc_o == e.pc, "pc_o", pc_o, e.pc);
          chk(inst_o == e.inst, "inst_o", inst_o, e.inst);
          if (e.pc == 32'hFFFF_FFFC) wrap_seen = 1;
          deliver_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    run = 1'b0;
    rst_n = 1'b0;
    sbq.delete(); memq.delete();
    drops = 0; model_pc = RESET_PC; acc_cnt = 0; deliver_cnt = 0;
    first_acc_cyc = -1; first_val_cyc = -1;
    force_br = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    run = 1'b1;
  endtask

  task automatic set_knobs(int en, int rdy, int id, int br, int rsp, int lmin, int lmax);
    k_en = en; k_rdy = rdy; k_id = id; k_br = br; k_rsp = rsp;
    k_lat_min = lmin; k_lat_max = lmax;
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    int d0;
    // Reset state
    fetch_en_i = 1'b1;
    #1;
    chk(mem_req_o == 1'b0, "rst_mem_req", 32'(mem_req_o), 32'd0);
    chk(mem_addr_o == RESET_PC, "rst_mem_addr", mem_addr_o, RESET_PC);
    chk(inst_valid_o == 1'b0, "rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk(inst_o == 32'd0, "rst_inst", inst_o, 32'd0);
    chk(pc_o == 32'd0, "rst_pc", pc_o, 32'd0);

    // Streaming with a one-cycle memory
    set_knobs(100, 100, 100, 0, 100, 1, 1);
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk(first_val_cyc - first_acc_cyc == 2, "first_latency",
        32'(first_val_cyc - first_acc_cyc), 32'd2);
    chk(acc_cnt - deliver_cnt == 2, "stream_one_per_cycle",
        32'(acc_cnt - deliver_cnt), 32'd2);

    // Decode stalled: credit stops at DEPTH, then drains in order
    set_knobs(100, 100, 0, 0, 100, 1, 1);
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    chk(acc_cnt == DEPTH, "stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk(mem_req_o == 1'b0, "stall_no_req", 32'(mem_req_o), 32'd0);
    k_id = 100;
    repeat (10) @(posedge clk);
    chk(deliver_cnt >= DEPTH, "stall_resume", 32'(deliver_cnt), 32'(DEPTH));

    // Redirect with three outstanding on a three-cycle memory
    set_knobs(100, 100, 100, 0, 100, 3, 3);
    do_reset();
    for (int i = 0; i < 50 && memq.size() != 3; i++) @(posedge clk);
    chk(memq.size() == 3, "three_outstanding", 32'(memq.size()), 32'd3);
    force_tgt = 32'h0000_0103;
    force_br  = 1'b1;
    repeat (20) @(posedge clk);
    chk(deliver_cnt > 0, "post_redirect_delivery", 32'(deliver_cnt), 32'd1);

    // Redirect in the same cycle as a response and a pop, then PC wrap
    set_knobs(100, 100, 100, 0, 100, 1, 1);
    do_reset();
    repeat (8) @(posedge clk);
    force_tgt = 32'hFFFF_FFFE;
    force_br  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(inst_valid_o == 1'b0, "flush_valid", 32'(inst_valid_o), 32'd0);
    d0 = deliver_cnt;
    repeat (10) @(posedge clk);
    chk(wrap_seen == 1, "wrap_delivered", 32'(wrap_seen), 32'd1);
    chk(deliver_cnt > d0 + 2, "wrap_continues", 32'(deliver_cnt), 32'(d0 + 3));

    // Asynchronous reset with two outstanding and two buffered
    set_knobs(100, 100, 0, 0, 100, 3, 3);
    do_reset();
    for (int i = 0; i < 50 && !(memq.size() == 2 && sbq.size() == 4); i++) @(posedge clk);
    chk(memq.size() == 2 && sbq.size() == 4, "mid_reset_setup",
        32'(memq.size()), 32'd2);
    #2;
    run = 1'b0;
    fetch_en_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk(inst_valid_o == 1'b0, "async_rst_valid", 32'(inst_valid_o), 32'd0);
    chk(mem_req_o == 1'b0, "async_rst_req", 32'(mem_req_o), 32'd0);
    chk(mem_addr_o == RESET_PC, "async_rst_addr", mem_addr_o, RESET_PC);

    // Randomised traffic after release
    set_knobs(90, 70, 70, 4, 70, 1, 4);
    do_reset();
    repeat (3000) @(posedge clk);
    set_knobs(0, 100, 100, 0, 100, 1, 4);
    for (int i = 0; i < 200 && (sbq.size() != 0 || memq.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk(sbq.size() == 0, "drain_sbq", 32'(sbq.size()), 32'd0);
    chk(memq.size() == 0, "drain_mem", 32'(memq.size()), 32'd0);
    chk(inst_valid_o == 1'b0, "drain_valid", 32'(inst_valid_o), 32'd0);
    chk(deliver_cnt > 100, "random_activity", 32'(deliver_cnt), 32'd101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
